// File: rtl/program_loader.sv
// Byte-stream program loader: parses framed images, writes big-endian words to program
// memory and releases the core only after a checksum-verified image has landed.
module program_loader #(
  parameter int unsigned MEMORY_DEPTH   = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IdxWidth = ADDR_WIDTH + 1;
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StCheck, StDone, StError
  } state_t;

  state_t                stateQ, stateD;
  logic [7:0]            lenHiQ, lenHiD;
  logic [IdxWidth-1:0]   lenQ, lenD;
  logic [IdxWidth-1:0]   idxQ, idxD;
  logic [7:0]            chkQ, chkD;
  logic [31:0]           wordQ, wordD;
  logic [1:0]            byteCntQ, byteCntD;
  logic [TmoWidth-1:0]   tmoQ, tmoD;
  logic                  memWeD;
  logic [ADDR_WIDTH-1:0] memAddrD;
  logic [31:0]           memWdataD;
  logic                  xfer;
  logic                  active;
  logic [15:0]           lenFull;

  assign xfer    = in_valid & in_ready;
  assign lenFull = {lenHiQ, in_data};
  assign active  = (stateQ == StLenHi) || (stateQ == StLenLo) ||
                   (stateQ == StData)  || (stateQ == StCheck);

  always_comb begin
    stateD    = stateQ;
    lenHiD    = lenHiQ;
    lenD      = lenQ;
    idxD      = idxQ;
    chkD      = chkQ;
    wordD     = wordQ;
    byteCntD  = byteCntQ;
    tmoD      = '0;
    memWeD    = 1'b0;
    memAddrD  = mem_addr;
    memWdataD = mem_wdata;

    // Idle time between bytes is only policed inside a frame.
    if (active && !xfer) begin
      if (tmoQ == TmoLast) begin
        stateD = StError;
      end else begin
        tmoD = tmoQ + 1'b1;
      end
    end

    if (xfer) begin
      unique case (stateQ)
        StIdle, StError: begin
          if (in_data == SYNC_BYTE) begin
            stateD = StLenHi;
            chkD   = '0;
          end
        end
        StLenHi: begin
          lenHiD = in_data;
          chkD   = chkQ + in_data;
          stateD = StLenLo;
        end
        StLenLo: begin
          chkD = chkQ + in_data;
          if (lenFull == 16'd0) begin
            stateD = StCheck;
          end else if (lenFull > 16'(MEMORY_DEPTH)) begin
            stateD = StError;
          end else begin
            stateD   = StData;
            lenD     = lenFull[IdxWidth-1:0];
            idxD     = '0;
            byteCntD = '0;
          end
        end
        StData: begin
          wordD    = {wordQ[23:0], in_data};
          chkD     = chkQ + in_data;
          byteCntD = byteCntQ + 2'd1;
          if (byteCntQ == 2'd3) begin
            memWeD    = 1'b1;
            memAddrD  = idxQ[ADDR_WIDTH-1:0];
            memWdataD = {wordQ[23:0], in_data};
            idxD      = idxQ + 1'b1;
            if (idxQ == lenQ - IdxWidth'(1)) begin
              stateD = StCheck;
            end
          end
        end
        StCheck: begin
          stateD = (in_data == chkQ) ? StDone : StError;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ    <= StIdle;
      lenHiQ    <= '0;
      lenQ      <= '0;
      idxQ      <= '0;
      chkQ      <= '0;
      wordQ     <= '0;
      byteCntQ  <= '0;
      tmoQ      <= '0;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      lenHiQ    <= lenHiD;
      lenQ      <= lenD;
      idxQ      <= idxD;
      chkQ      <= chkD;
      wordQ     <= wordD;
      byteCntQ  <= byteCntD;
      tmoQ      <= tmoD;
      in_ready  <= (stateD != StDone);
      mem_we    <= memWeD;
      mem_addr  <= memAddrD;
      mem_wdata <= memWdataD;
      cpu_hold  <= (stateD != StDone);
      done      <= (stateD == StDone);
      error     <= (stateD == StError);
    end
  end

endmodule
